// File: rtl/cp_inserter_if.sv
// Stream bundle for the cyclic-prefix inserter: upstream sample input with
// ready backpressure, and downstream sample output with valid/ready.
interface cp_inserter_if #(
  parameter int W = 16
);
  logic signed [W-1:0] in_i;
  logic signed [W-1:0] in_q;
  logic                in_valid;
  logic                in_sop;
  logic                ready_out;
  logic signed [W-1:0] out_i;
  logic signed [W-1:0] out_q;
  logic                out_valid;
  logic                out_sop;
  logic                out_eop;
  logic                out_ready;

  modport slave (
    input  in_i, in_q, in_valid, in_sop, out_ready,
    output ready_out, out_i, out_q, out_valid, out_sop, out_eop
  );

  modport master (
    output in_i, in_q, in_valid, in_sop, out_ready,
    input  ready_out, out_i, out_q, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/cp_inserter.sv
// Buffers N-sample OFDM symbols in a ping-pong RAM and replays each one
// prefixed with its last CP samples, with a skid stage on the output.
module cp_inserter #(
  parameter int N  = 64,
  parameter int CP = 16,
  parameter int W  = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  cp_inserter_if.slave bus,
  output logic         sop_err
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST     = AW'(N - 1);
  localparam logic [AW-1:0] CP_START = AW'(N - CP);

  typedef enum logic {
    WR_WAIT_SOP,
    WR_FILL
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_CP,
    RD_BODY
  } rd_state_e;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [W-1:0] i;
    logic [W-1:0] q;
  } word_t;

  logic [2*W-1:0] mem [2*N];

  wr_state_e     wr_state_q;
  logic [AW-1:0] wr_addr_q;
  logic          wr_bank_q;
  logic          sop_err_q;
  rd_state_e     rd_state_q;
  logic [AW-1:0] rd_addr_q;
  logic          rd_bank_q;
  logic [1:0]    full_q;
  logic [1:0]    full_d;
  word_t         out_word_q;
  logic          out_valid_q;
  word_t         skid_word_q;
  logic          skid_valid_q;

  logic          accept;
  logic          wr_we;
  logic          wr_done;
  logic [AW-1:0] wr_waddr;
  logic [AW-1:0] rd_raddr;
  logic          rd_body;
  logic          rd_last;
  logic          rd_fire;
  logic          rd_release;
  logic          pop;
  word_t         rd_word;

  assign bus.ready_out = ~full_q[wr_bank_q] & enable & ~reset;
  assign accept        = enable & bus.in_valid & bus.ready_out;

  // A sop always restarts the symbol at address 0, whatever state we are in.
  always_comb begin
    wr_we    = 1'b0;
    wr_done  = 1'b0;
    wr_waddr = '0;
    if (accept) begin
      if (bus.in_sop) begin
        wr_we = 1'b1;
      end else if (wr_state_q == WR_FILL) begin
        wr_we    = 1'b1;
        wr_waddr = wr_addr_q;
        wr_done  = (wr_addr_q == LAST);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state_q <= WR_WAIT_SOP;
      wr_addr_q  <= '0;
      wr_bank_q  <= 1'b0;
      sop_err_q  <= 1'b0;
    end else if (accept) begin
      if (bus.in_sop) begin
        if (wr_state_q == WR_FILL) sop_err_q <= 1'b1;
        wr_state_q <= WR_FILL;
        wr_addr_q  <= AW'(1);
      end else if (wr_state_q == WR_FILL) begin
        if (wr_done) begin
          wr_state_q <= WR_WAIT_SOP;
          wr_addr_q  <= '0;
          wr_bank_q  <= ~wr_bank_q;
        end else begin
          wr_addr_q <= wr_addr_q + AW'(1);
        end
      end
    end
  end

  // NOTE: the sample RAM has no reset; bank validity lives in full_q, and a
  // reset port on the array would prevent block-RAM mapping.
  always_ff @(posedge clock) begin
    if (wr_we) mem[{wr_bank_q, wr_waddr}] <= {bus.in_i, bus.in_q};
  end

  // From IDLE the first CP address is issued directly so the prefix starts
  // the cycle after the bank becomes full.
  assign rd_raddr   = (rd_state_q == RD_IDLE) ? CP_START : rd_addr_q;
  assign rd_body    = (rd_state_q == RD_BODY);
  assign rd_last    = (rd_raddr == LAST);
  assign rd_fire    = enable & ~skid_valid_q &
                      ((rd_state_q != RD_IDLE) | full_q[rd_bank_q]);
  assign rd_release = rd_fire & rd_body & rd_last;

  always_comb begin
    rd_word.sop = ~rd_body & (rd_raddr == CP_START);
    rd_word.eop = rd_body & rd_last;
    {rd_word.i, rd_word.q} = mem[{rd_bank_q, rd_raddr}];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= '0;
      rd_bank_q  <= 1'b0;
    end else if (rd_fire) begin
      case (rd_state_q)
        RD_IDLE, RD_CP: begin
          if (rd_last) begin
            rd_state_q <= RD_BODY;
            rd_addr_q  <= '0;
          end else begin
            rd_state_q <= RD_CP;
            rd_addr_q  <= rd_raddr + AW'(1);
          end
        end
        RD_BODY: begin
          if (rd_last) begin
            rd_bank_q <= ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              rd_state_q <= RD_CP;
              rd_addr_q  <= CP_START;
            end else begin
              rd_state_q <= RD_IDLE;
              rd_addr_q  <= '0;
            end
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // Release is applied after completion so the read side wins on a shared bit.
  always_comb begin
    full_d = full_q;
    if (wr_done)    full_d[wr_bank_q] = 1'b1;
    if (rd_release) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) full_q <= '0;
    else       full_q <= full_d;
  end

  // Reads are issued from registered state only; a read landing while the
  // output is stalled parks in the skid register.
  assign pop = enable & out_valid_q & bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_word_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_word_q  <= '0;
      skid_valid_q <= 1'b0;
    end else if (enable) begin
      if (!out_valid_q || pop) begin
        if (skid_valid_q) begin
          out_word_q   <= skid_word_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (rd_fire) begin
          out_word_q  <= rd_word;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (rd_fire) begin
        skid_word_q  <= rd_word;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign bus.out_i     = out_word_q.i;
  assign bus.out_q     = out_word_q.q;
  assign bus.out_sop   = out_word_q.sop;
  assign bus.out_eop   = out_word_q.eop;
  assign bus.out_valid = out_valid_q;
  assign sop_err       = sop_err_q;

endmodule

// File: doc/cp_inserter.md
Name: cp_inserter

Overview:
- Consumes the frequency/time-domain I/Q symbol stream produced by the OFDM preamble/symbol assembly stage (16-bit signed I/Q plus sop).
- Buffers each N-sample OFDM symbol in a ping-pong RAM.
- Emits the symbol prefixed with its last CP samples (cyclic prefix) toward the DAC/framing stage.
- Provides backpressure upstream via ready_out, since output rate (N+CP) exceeds input rate (N).

Parameters:
N, 64, samples per OFDM symbol (power of 2, 16..2048)
CP, 16, cyclic prefix length (1..N-1)
W, 16, I/Q sample width (signed)

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
enable  in  1  global enable; low freezes all state and outputs
in_i  in  W  input sample I, signed
in_q  in  W  input sample Q, signed
in_valid  in  1  input sample valid
in_sop  in  1  first sample of a symbol, qualified by in_valid
ready_out  out  1  block can accept an input sample this cycle
out_i  out  W  output sample I, signed
out_q  out  W  output sample Q, signed
out_valid  out  1  output sample valid
out_sop  out  1  first CP sample of output symbol
out_eop  out  1  last body sample of output symbol
out_ready  in  1  downstream accepts output this cycle
sop_err  out  1  sticky: in_sop seen mid-symbol

Behaviour:
- Reset (async, active-high): all outputs 0, except ready_out 0 during reset and 1 on the first enabled cycle after release. Both banks empty, write FSM in WAIT_SOP, read FSM in IDLE. Reset mid-symbol discards all buffered data.
- enable=0: no state change, outputs hold, no sample is accepted regardless of in_valid.
- Accept condition: enable & in_valid & ready_out.
- Write FSM WAIT_SOP: accepted samples without in_sop are dropped. An accepted sample with in_sop is written to address 0, and the FSM goes to FILL with wr_addr=1.
- Write FSM FILL: each accepted sample is written at wr_addr, which then increments. When sample N-1 is written, the bank is marked full, the write bank toggles, and the FSM returns to WAIT_SOP.
- In_sop accepted in FILL (wr_addr≠0): sop_err is set (sticky until reset), the sample is written at address 0, and wr_addr=1. The partial symbol is discarded.
- ready_out = (write bank not full) & enable & ~reset. It is low while both banks are full.
- Read FSM IDLE: when the read bank is full, go to CP with rd_addr=N-CP.
- Read FSM CP: advance rd_addr through N-CP..N-1, then go to BODY with rd_addr=0.
- Read FSM BODY: advance rd_addr through 0..N-1. After N-1: mark bank empty, toggle the read bank, then go to CP if the other bank is full, else IDLE. There is no gap cycle between back-to-back symbols.
- RAM read is synchronous: 1-cycle latency to a 1-deep output register.
- First out_valid occurs 2 cycles after the cycle in which the Nth sample is accepted.
- Output handshake: transfer when out_valid & out_ready.
- out_valid=1 & out_ready=0: out_i, out_q, out_sop and out_eop hold stable, and the read pointer stalls. A skid register is required so that no sample is lost or duplicated.
- out_sop=1 only on the sample from address N-CP. out_eop=1 only on the body sample from address N-1.
- Each symbol produces exactly N+CP outputs.
- Samples pass bit-exact; no arithmetic is performed.
- A bank is released (marked empty) the cycle after its last body address is read. That bank may be written in the same cycle it is released, and the read side takes priority for the status bit.
- Simultaneous events: the write side completing one bank while the read side releases the other is legal, and both take effect.

Test Plan:
- N=64, CP=16, single symbol, in_i=0..63, in_q=-(0..63), out_ready=1 -> 80 outputs: in_i 48..63 then 0..63. out_sop on first output (value 48), out_eop on last (63). First out_valid 2 cycles after sample 63 accepted.
- Three back-to-back symbols, in_valid=1 continuously -> ready_out drops low after second symbol fills. Output is a continuous 240-cycle out_valid stream with no gaps. Symbol order preserved.
- in_sop re-asserted at sample 20 of a symbol -> sop_err=1 and stays 1. The first 20 samples are discarded, and the symbol restarts from the new sop. Output contains only the restarted symbol.
- out_ready toggled 1,0,0,1 pseudo-randomly during output -> every sample emitted exactly once, in order. Outputs stable while stalled. Total transfers = 80 per symbol.
- enable=0 for 5 cycles mid-CP, and samples presented on in_valid during that window -> outputs frozen, input samples not accepted. Output resumes at the exact next address.
- reset pulsed (async, mid-clock) during BODY of symbol 1 with symbol 2 buffered -> all outputs 0 immediately. No stale output after release. The next symbol starting with in_sop is output correctly.
